// File: rtl/fb_fill_engine.sv
// fb_fill_engine: Avalon-MM burst master filling a clipped framebuffer rectangle, with vsync-aligned double-buffer swap
module fb_fill_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter logic [ADDR_W-1:0] BASE0 = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] BASE1 = 32'h0002_5800,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            color,
    input  logic [15:0]                  x0,
    input  logic [15:0]                  y0,
    input  logic [15:0]                  w,
    input  logic [15:0]                  h,
    input  logic                         swap_req,
    input  logic                         vsync,
    output logic                         busy,
    output logic                         done,
    output logic                         front_sel,
    output logic [ADDR_W-1:0]            m_address,
    output logic                         m_write,
    output logic [DATA_W-1:0]            m_writedata,
    output logic [DATA_W/8-1:0]          m_byteenable,
    output logic [$clog2(MAX_BURST):0]   m_burstcount,
    input  logic                         m_waitrequest
);
    localparam int BPP = DATA_W / 8;
    localparam int BCW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, ROW, BURST, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] col;
    logic [ADDR_W-1:0] base, row_addr;
    logic [15:0] xr, yr, wc, hc, r, rem, w_clip, h_clip;
    logic [BCW-1:0] cnt, row_bc, nxt_bc;
    logic signed [16:0] xspan, yspan;
    logic pend, apply, front_nx, fill_ok, last, more_rows;

    function automatic logic [BCW-1:0] bc_of(input logic [15:0] n);
        return (n >= 16'(MAX_BURST)) ? BCW'(MAX_BURST) : BCW'(n);
    endfunction

    // signed spans so an origin beyond the edge yields a non-positive span
    assign xspan = $signed(17'(H_RES)) - $signed({1'b0, x0});
    assign yspan = $signed(17'(V_RES)) - $signed({1'b0, y0});
    assign w_clip = ($signed({1'b0, w}) < xspan) ? w : xspan[15:0];
    assign h_clip = ($signed({1'b0, h}) < yspan) ? h : yspan[15:0];
    assign fill_ok = !(xspan <= 17'sd0 || yspan <= 17'sd0 || w == 16'd0 || h == 16'd0);
    assign apply = vsync && (pend || swap_req) && state == IDLE;
    assign front_nx = front_sel ^ apply;
    assign last = state == BURST && !m_waitrequest && cnt == BCW'(1);
    assign more_rows = ({1'b0, r} + 17'd1) < {1'b0, hc};
    assign row_bc = bc_of(wc);
    assign nxt_bc = bc_of(rem);
    assign row_addr = base + ((ADDR_W'(yr) + ADDR_W'(r)) * ADDR_W'(H_RES) + ADDR_W'(xr)) * ADDR_W'(BPP);
    assign m_writedata = col;
    assign m_byteenable = '1;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // next-state: bursts chain within a row, one ROW cycle between rows
    always_comb begin
        state_nx = state == IDLE  ? (start ? (fill_ok ? ROW : DONE) : IDLE) :
                   state == ROW   ? BURST :
                   state == BURST ? (!last ? BURST : rem != 16'd0 ? BURST : more_rows ? ROW : DONE) :
                                    IDLE;
    end

    // state-decoded outputs so reset clears them immediately
    always_comb begin
        busy = state == ROW || state == BURST;
        done = state == DONE;
        m_write = state == BURST;
    end

    // swap is pending until a vsync seen while idle; a same-cycle start sees the new front
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel <= 1'b0;
            pend <= 1'b0;
        end else begin
            front_sel <= front_nx;
            pend <= !apply && (pend || swap_req);
        end
    end

    // fill datapath: latch request, compute row start, advance bursts on accepted beats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            base <= '0;
            xr <= '0;
            yr <= '0;
            wc <= '0;
            hc <= '0;
            r <= '0;
            rem <= '0;
            cnt <= '0;
            m_address <= '0;
            m_burstcount <= '0;
        end else begin
            if (state == IDLE && start) begin
                col <= color;
                base <= front_nx ? BASE0 : BASE1;
                xr <= x0;
                yr <= y0;
                wc <= w_clip;
                hc <= h_clip;
                r <= '0;
            end
            if (state == ROW) begin
                m_address <= row_addr;
                m_burstcount <= row_bc;
                cnt <= row_bc;
                rem <= wc - 16'(row_bc);
            end
            if (state == BURST && !m_waitrequest) begin
                cnt <= cnt - 1'b1;
                if (cnt == BCW'(1)) begin
                    if (rem != 16'd0) begin
                        m_address <= m_address + ADDR_W'(m_burstcount) * ADDR_W'(BPP);
                        m_burstcount <= nxt_bc;
                        cnt <= nxt_bc;
                        rem <= rem - 16'(nxt_bc);
                    end else begin
                        r <= r + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: randomized bench with a per-cycle behavioural model of fills, bursts and swaps
module tb_fb_fill_engine;
    logic clk = 0, reset = 1, start = 0, swap_req = 0, vsync = 0, m_waitrequest = 0;
    logic [15:0] color = 0, x0 = 0, y0 = 0, w = 0, h = 0;
    logic busy, done, front_sel, m_write;
    logic [31:0] m_address;
    logic [15:0] m_writedata;
    logic [1:0] m_byteenable;
    logic [3:0] m_burstcount;

    fb_fill_engine dut (
        .clk(clk), .reset(reset), .start(start), .color(color), .x0(x0), .y0(y0), .w(w), .h(h),
        .swap_req(swap_req), .vsync(vsync), .busy(busy), .done(done), .front_sel(front_sel),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {logic [31:0] addr; int bc; bit nr;} burst_t;
    burst_t mq[$], m_plan[$];
    bit m_in_fill = 0, m_done_due = 0, m_gap_done = 0, m_front = 0, m_pend = 0;
    bit dn_next, exp_w, apply;
    int m_left = 0, m_beats = 0, m_dones = 0;
    logic [15:0] m_color = 0;
    bit wr_rand = 0;

    // every burst of a fill as a list, straight from the rectangle arithmetic
    function automatic void plan(input int x, input int y, input int ww, input int hh, input logic [31:0] base);
        int wc, hc, rem, bc;
        logic [31:0] a;
        mq.delete();
        if (x >= 320 || y >= 240 || ww == 0 || hh == 0) return;
        wc = ww < 320 - x ? ww : 320 - x;
        hc = hh < 240 - y ? hh : 240 - y;
        for (int rr = 0; rr < hc; rr++) begin
            a = base + 32'(((y + rr) * 320 + x) * 2);
            rem = wc;
            for (int f = 1; rem > 0; f = 0) begin
                bc = rem < 8 ? rem : 8;
                mq.push_back('{a, bc, f[0]});
                a += 32'(bc * 2);
                rem -= bc;
            end
        end
    endfunction

    // compare DUT against the model on every cycle, then advance the model
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_in_fill = 0; m_done_due = 0; m_gap_done = 0; m_front = 0; m_pend = 0;
        end else begin
            dn_next = 0;
            exp_w = 0;
            chk("done", done, m_done_due);
            chk("busy", busy, m_in_fill && !m_done_due);
            chk("front_sel", front_sel, m_front);
            if (m_in_fill && !m_done_due && mq.size() > 0) begin
                if (mq[0].nr && !m_gap_done) m_gap_done = 1;
                else begin
                    exp_w = 1;
                    chk("m_address", m_address, mq[0].addr);
                    chk("m_burstcount", m_burstcount, mq[0].bc);
                    chk("m_writedata", m_writedata, m_color);
                    chk("m_byteenable", m_byteenable, 2'b11);
                    if (!m_waitrequest) begin
                        m_beats++;
                        m_left--;
                        if (m_left == 0) begin
                            void'(mq.pop_front());
                            m_gap_done = 0;
                            if (mq.size() == 0) dn_next = 1;
                            else m_left = mq[0].bc;
                        end
                    end
                end
            end
            chk("m_write", m_write, exp_w);
            if (done) m_dones++;
            apply = !m_in_fill && vsync && (m_pend || swap_req);
            m_pend = !apply && (m_pend || swap_req);
            if (apply) m_front = !m_front;
            if (m_in_fill) begin
                if (m_done_due) m_in_fill = 0;
            end else if (start) begin
                plan(x0, y0, w, h, m_front ? 32'h0 : 32'h0002_5800);
                m_plan = mq;
                m_in_fill = 1;
                m_color = color;
                m_beats = 0;
                m_gap_done = 0;
                if (mq.size() == 0) dn_next = 1;
                else m_left = mq[0].bc;
            end
            m_done_due = dn_next;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 m_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic wait_idle(input bit noise);
        int n = 0;
        while (m_in_fill && n < 4000) begin
            @(posedge clk);
            #1;
            if (noise) begin
                start = $urandom_range(0, 5) == 0;
                swap_req = $urandom_range(0, 9) == 0;
                vsync = $urandom_range(0, 9) == 0;
            end
            n++;
        end
        start = 0; swap_req = 0; vsync = 0;
        if (n >= 4000) chk("timeout", 1, 0);
    endtask

    task automatic fill(input int x, input int y, input int ww, input int hh, input logic [15:0] c, input bit sw, input bit vs, input bit noise);
        int d0;
        @(posedge clk);
        #1;
        x0 = 16'(x); y0 = 16'(y); w = 16'(ww); h = 16'(hh); color = c;
        start = 1; swap_req = sw; vsync = vs;
        d0 = m_dones;
        @(posedge clk);
        #1 start = 0; swap_req = 0; vsync = 0;
        wait_idle(noise);
        @(posedge clk);
        #1 chk("done_count", m_dones - d0, 1);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_front", front_sel, 0);
        chk("rst_write", m_write, 0);
        chk("rst_addr", m_address, 0);
        chk("rst_bc", m_burstcount, 0);
        chk("rst_data", m_writedata, 0);
        @(posedge clk);
        #1 reset = 0;
        repeat (3) @(posedge clk);

        fill(10, 2, 20, 3, 16'hF800, 0, 0, 0);
        chk("t1_bursts", m_plan.size(), 9);
        chk("t1_addr0", m_plan[0].addr, 32'h25D14);
        chk("t1_bc2", m_plan[2].bc, 4);
        chk("t1_addr_row1", m_plan[3].addr, 32'h25F94);
        chk("t1_beats", m_beats, 60);

        fill(315, 238, 20, 10, 16'h07E0, 0, 0, 0);
        chk("clip_bursts", m_plan.size(), 2);
        chk("clip_addr0", m_plan[0].addr, 32'h4AD76);
        chk("clip_addr1", m_plan[1].addr, 32'h4AFF6);
        chk("clip_bc", m_plan[1].bc, 5);
        chk("clip_beats", m_beats, 10);

        fill(320, 0, 5, 5, 16'h1234, 0, 0, 0);
        chk("degen_x_beats", m_beats, 0);
        fill(0, 0, 5, 0, 16'h1234, 0, 0, 0);
        chk("degen_h_beats", m_beats, 0);

        @(posedge clk);
        #1 x0 = 0; y0 = 0; w = 30; h = 4; color = 16'hABCD; start = 1;
        @(posedge clk);
        #1 start = 0; swap_req = 1;
        @(posedge clk);
        #1 swap_req = 0; vsync = 1;
        @(posedge clk);
        #1 vsync = 0;
        wait_idle(0);
        chk("swap_held_front", front_sel, 0);
        @(posedge clk);
        #1 vsync = 1;
        @(posedge clk);
        #1 vsync = 0;
        chk("swap_applied_front", front_sel, 1);
        fill(0, 0, 4, 1, 16'h0F0F, 0, 0, 0);
        chk("swap_target_base0", m_plan[0].addr, 32'h0);
        fill(0, 0, 1, 1, 16'h5555, 1, 1, 0);
        chk("same_cycle_front", front_sel, 0);
        chk("same_cycle_target", m_plan[0].addr, 32'h25800);

        wr_rand = 1;
        for (int i = 0; i < 20; i++)
            fill($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 40), $urandom_range(0, 6),
                 16'($urandom), 0, 0, 1);
        wr_rand = 0;
        @(posedge clk);
        #1 swap_req = 1; vsync = 1;
        @(posedge clk);
        #1 swap_req = 0; vsync = 0;

        @(posedge clk);
        #1 x0 = 0; y0 = 0; w = 100; h = 5; start = 1;
        @(posedge clk);
        #1 start = 0;
        n = 0;
        while (!m_write && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("burst_started", m_write, 1);
        #2 reset = 1;
        #1;
        chk("midrst_write", m_write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_front", front_sel, 0);
        chk("midrst_addr", m_address, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
        repeat (4) @(posedge clk);
        #1 chk("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
